cordic_sched: RTL and testbench
===============================

CORDIC_SCHED -- requirements
Module: cordic_sched

Interface
REQ-001 Parameter N_REQ, default 4, number of requester ports (2..8).
REQ-002 Parameter W_NIO, default 16, width of each x/y/z operand and result.
REQ-003 Parameter LAT, default 21, latency of the attached CORDIC core from input to output, in clk cycles.
REQ-004 clk  input  1  system clock; one clock domain.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req_vld  input  N_REQ  per-port request valid.
REQ-007 req_rdy  output  N_REQ  per-port grant, one-hot or zero, combinational from req_vld and the arbitration pointer.
REQ-008 req_x, req_y, req_z  input  N_REQ*W_NIO each  operands; port k occupies bits [W_NIO*(k+1)-1 : W_NIO*k]; signed; z is in units of Pi.
REQ-009 core_x, core_y, core_z  output  W_NIO each  registered operands driven to the CORDIC core.
REQ-010 core_rx, core_ry, core_rz  input  W_NIO each  core results.
REQ-011 rsp_vld  output  N_REQ  one-hot result strobe, one cycle per result; no backpressure.
REQ-012 rsp_x, rsp_y, rsp_z  output  W_NIO each  shared result bus; valid only when rsp_vld is nonzero.
REQ-013 inflight  output  $clog2(LAT+2)  count of accepted, undelivered operations.
REQ-014 busy  output  1  high when inflight is nonzero.

Function
REQ-015 A request on port k is accepted in a cycle when req_vld[k] and req_rdy[k] are both high; at most one acceptance per cycle.
REQ-016 req_rdy is zero when req_vld is zero; otherwise it grants exactly one valid port, chosen by round-robin: search starts at port ptr and wraps from N_REQ-1 to 0.
REQ-017 After an acceptance on port k, ptr becomes (k+1) mod N_REQ; with no acceptance, ptr holds.
REQ-018 On acceptance, the next clk edge loads core_x/y/z with the granted operands; with no acceptance, core_x/y/z hold their values.
REQ-019 A tag pipeline of depth LAT+1, holding a valid bit and a port index, advances every cycle; stage 0 loads {acceptance, granted index}.
REQ-020 Result timing: rsp_vld[k] asserts exactly LAT+1 cycles after the acceptance cycle, with rsp_x/y/z = core_rx/ry/rz in that cycle (combinational pass-through).
REQ-021 Throughput: one acceptance per cycle sustained; back-to-back results from different ports produce consecutive single-cycle strobes in acceptance order.
REQ-022 inflight increments on acceptance and decrements on rsp strobe; an acceptance and a strobe in the same cycle leave it unchanged; maximum value is LAT+1.
REQ-023 A requester that drops req_vld without being granted loses nothing; no state is recorded for it.
REQ-024 rsp_x/y/z are unspecified when rsp_vld is zero.

Reset
REQ-025 While rst is high: req_rdy = 0, rsp_vld = 0, ptr = 0, all tag valid bits = 0, core_x/y/z = 0, inflight = 0, busy = 0.
REQ-026 Reset mid-operation discards all in-flight operations: no rsp_vld is produced for operations accepted before reset, even though the core still drains them.
REQ-027 The first acceptance is possible in the first cycle rst is low.

Configuration
REQ-028 Macro CORDIC_SCHED_PRIO0_EN: when defined, port 0 is granted whenever req_vld[0] is high, round-robin applies among ports 1..N_REQ-1 only, and a port-0 grant leaves ptr unchanged.
REQ-029 Without CORDIC_SCHED_PRIO0_EN, all ports are in the round-robin rotation per REQ-016/017.

Verification (core attached, rotation mode, LAT = 21)
REQ-030 Test 1: port 2 requests x=0x4000, y=0, z=0x2000 with the others idle. Required: rsp_vld = 4'b0100 exactly 22 cycles later, rsp_x and rsp_y both 0x2D41 within ±2 LSB, inflight = 1 for those 22 cycles.
REQ-031 Test 2: all four ports hold req_vld high for 8 cycles starting from reset. Required: grant order 0,1,2,3,0,1,2,3; rsp strobes follow in the same order on 8 consecutive cycles; inflight peaks at 8.
REQ-032 Test 3: ports 1 and 3 valid, ptr = 2. Required: port 3 is granted first, then port 1.
REQ-033 Test 4: rst asserted for 1 cycle, 5 cycles after 3 acceptances. Required: no rsp_vld within the next 30 cycles; inflight = 0 after reset.
REQ-034 Test 5: continuous one request per cycle for 100 cycles. Required: inflight saturates at 22 and never exceeds it; results are bit-exact against a model of the core.
REQ-035 Test 6 (with CORDIC_SCHED_PRIO0_EN): ports 0 and 1 continuously valid. Required: only port 0 is granted. Repeat without the macro. Required: ports 0 and 1 alternate.

Source files
------------

// File: rtl/cordic_sched.sv
// Round-robin scheduler sharing one pipelined CORDIC core among N_REQ requesters.
// Define CORDIC_SCHED_PRIO0_EN to give port 0 absolute priority over the rotation.
module cordic_sched #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned W_NIO = 16,
  parameter int unsigned LAT   = 21
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_vld,
  output logic [N_REQ-1:0]           req_rdy,
  input  logic [N_REQ*W_NIO-1:0]     req_x,
  input  logic [N_REQ*W_NIO-1:0]     req_y,
  input  logic [N_REQ*W_NIO-1:0]     req_z,
  output logic [W_NIO-1:0]           core_x,
  output logic [W_NIO-1:0]           core_y,
  output logic [W_NIO-1:0]           core_z,
  input  logic [W_NIO-1:0]           core_rx,
  input  logic [W_NIO-1:0]           core_ry,
  input  logic [W_NIO-1:0]           core_rz,
  output logic [N_REQ-1:0]           rsp_vld,
  output logic [W_NIO-1:0]           rsp_x,
  output logic [W_NIO-1:0]           rsp_y,
  output logic [W_NIO-1:0]           rsp_z,
  output logic [$clog2(LAT+2)-1:0]   inflight,
  output logic                       busy
);

  localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PW-1:0]    ptr;
  logic [PW-1:0]    cand;
  logic [PW-1:0]    gnt_idx;
  logic             acc;
  logic             ptr_adv;
  logic             strobe;
  logic [W_NIO-1:0] sel_x, sel_y, sel_z;
  logic [LAT:0]     tag_vld;
  logic [PW-1:0]    tag_idx [LAT+1];

  // Round-robin search starting at ptr; reset suppresses every grant.
  always_comb begin
    gnt_idx = '0;
    acc     = 1'b0;
    cand    = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = PW'((32'(ptr) + i) % N_REQ);
      if (!acc && req_vld[cand]) begin
        acc     = 1'b1;
        gnt_idx = cand;
      end
    end
`ifdef CORDIC_SCHED_PRIO0_EN
    if (req_vld[0]) begin
      acc     = 1'b1;
      gnt_idx = '0;
    end
`endif
    if (rst) acc = 1'b0;
  end

`ifdef CORDIC_SCHED_PRIO0_EN
  assign ptr_adv = acc && !req_vld[0];
`else
  assign ptr_adv = acc;
`endif

  always_comb begin
    req_rdy = '0;
    if (acc) req_rdy[gnt_idx] = 1'b1;
  end

  always_comb begin
    sel_x = '0;
    sel_y = '0;
    sel_z = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (gnt_idx == PW'(k)) begin
        sel_x = req_x[k*W_NIO +: W_NIO];
        sel_y = req_y[k*W_NIO +: W_NIO];
        sel_z = req_z[k*W_NIO +: W_NIO];
      end
    end
  end

  assign strobe = tag_vld[LAT];

  // Control state: pointer, operand register, tag valid chain, occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= '0;
      core_x   <= '0;
      core_y   <= '0;
      core_z   <= '0;
      tag_vld  <= '0;
      inflight <= '0;
    end else begin
      tag_vld <= {tag_vld[LAT-1:0], acc};
      if (acc) begin
        core_x <= sel_x;
        core_y <= sel_y;
        core_z <= sel_z;
      end
      if (ptr_adv) ptr <= (gnt_idx == PW'(N_REQ-1)) ? '0 : gnt_idx + 1'b1;
      case ({acc, strobe})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

  // Port indices ride alongside the valid chain; they need no reset.
  always_ff @(posedge clk) begin
    tag_idx[0] <= gnt_idx;
    for (int unsigned i = 1; i <= LAT; i++) tag_idx[i] <= tag_idx[i-1];
  end

  always_comb begin
    rsp_vld = '0;
    if (strobe && !rst) rsp_vld[tag_idx[LAT]] = 1'b1;
  end

  assign rsp_x = core_rx;
  assign rsp_y = core_ry;
  assign rsp_z = core_rz;
  assign busy  = (inflight != '0);

endmodule

// File: tb/tb_cordic_sched.sv
// Scoreboard bench for cordic_sched with a behavioural LAT-cycle CORDIC core attached.
module tb_cordic_sched;

  localparam int unsigned N   = 4;
  localparam int unsigned W   = 16;
  localparam int unsigned LAT = 21;
  localparam int unsigned CW  = $clog2(LAT+2);
  localparam int          DLY = LAT + 1;

  logic           clk, rst;
  logic [N-1:0]   req_vld, req_rdy, rsp_vld;
  logic [N*W-1:0] req_x, req_y, req_z;
  logic [W-1:0]   core_x, core_y, core_z, core_rx, core_ry, core_rz;
  logic [W-1:0]   rsp_x, rsp_y, rsp_z;
  logic [CW-1:0]  inflight;
  logic           busy;

  cordic_sched #(.N_REQ(N), .W_NIO(W), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_rdy(req_rdy),
    .req_x(req_x), .req_y(req_y), .req_z(req_z),
    .core_x(core_x), .core_y(core_y), .core_z(core_z),
    .core_rx(core_rx), .core_ry(core_ry), .core_rz(core_rz),
    .rsp_vld(rsp_vld), .rsp_x(rsp_x), .rsp_y(rsp_y), .rsp_z(rsp_z),
    .inflight(inflight), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int peak  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Rotation-mode CORDIC, z in units of pi, gain compensated.
  function automatic void cordic_f(input logic [W-1:0] xi, input logic [W-1:0] yi,
                                   input logic [W-1:0] zi, output logic [W-1:0] xo,
                                   output logic [W-1:0] yo, output logic [W-1:0] zo);
    int  x, y, z, xn, at;
    real k;
    x = int'($signed(xi)) * 256;
    y = int'($signed(yi)) * 256;
    z = int'($signed(zi));
    k = 1.0;
    if (z > 16384) begin
      x = -x; y = -y; z = z - 32768;
    end else if (z < -16384) begin
      x = -x; y = -y; z = z + 32768;
    end
    z = z * 256;
    for (int i = 0; i < 16; i++) begin
      at = int'($atan(1.0 / real'(1 << i)) / 3.141592653589793 * 8388608.0);
      k  = k / $sqrt(1.0 + 1.0 / real'(1 << (2 * i)));
      if (z >= 0) begin
        xn = x - (y >>> i); y = y + (x >>> i); x = xn; z = z - at;
      end else begin
        xn = x + (y >>> i); y = y - (x >>> i); x = xn; z = z + at;
      end
    end
    xo = W'(int'(real'(x) * k / 256.0));
    yo = W'(int'(real'(y) * k / 256.0));
    zo = W'(z >>> 8);
  endfunction

  // Attached core: samples core_x/y/z each edge, result appears LAT cycles later.
  logic [W-1:0] px [LAT];
  logic [W-1:0] py [LAT];
  logic [W-1:0] pz [LAT];
  logic [W-1:0] ca, cb, cc;
  always @(posedge clk) begin
    cordic_f(core_x, core_y, core_z, ca, cb, cc);
    px[0] <= ca; py[0] <= cb; pz[0] <= cc;
    for (int i = 1; i < LAT; i++) begin
      px[i] <= px[i-1]; py[i] <= py[i-1]; pz[i] <= pz[i-1];
    end
  end
  assign core_rx = px[LAT-1];
  assign core_ry = py[LAT-1];
  assign core_rz = pz[LAT-1];

  typedef struct {
    int           port;
    logic [W-1:0] x, y, z;
    int           due;
  } exp_t;
  exp_t sbq[$];

  // Reference arbiter and occupancy model; pushes expected responses.
  int            ptr_m = 0;
  logic [DLY-1:0] hist = '0;
  int            gi;
  logic [N-1:0]  eg;
  exp_t          ne;
  always @(negedge clk) begin
    chk("inflight", 64'(inflight), 64'($countones(hist)));
    chk("busy", 64'(busy), 64'(hist != '0));
    if (int'(inflight) > peak) peak = int'(inflight);
    gi = -1;
    if (!rst) begin
`ifdef CORDIC_SCHED_PRIO0_EN
      if (req_vld[0]) gi = 0;
`endif
      for (int o = 0; o < N; o++)
        if (gi < 0 && req_vld[(ptr_m + o) % N]) gi = (ptr_m + o) % N;
    end
    eg = '0;
    if (gi >= 0) eg[gi] = 1'b1;
    chk("req_rdy", 64'(req_rdy), 64'(eg));
    if (gi >= 0) begin
      ne.port = gi;
      ne.due  = cyc + DLY;
      cordic_f(req_x[gi*W +: W], req_y[gi*W +: W], req_z[gi*W +: W], ne.x, ne.y, ne.z);
      sbq.push_back(ne);
`ifdef CORDIC_SCHED_PRIO0_EN
      if (gi != 0) ptr_m = (gi + 1) % N;
`else
      ptr_m = (gi + 1) % N;
`endif
    end
    hist = {hist[DLY-2:0], gi >= 0};
    if (rst) begin
      hist  = '0;
      ptr_m = 0;
    end
  end

  // Monitor: every strobe must match the head of the scoreboard on its due cycle.
  exp_t me;
  always @(negedge clk) begin
    if (rst) begin
      chk("rsp_vld_in_reset", 64'(rsp_vld), 64'(0));
      sbq.delete();
    end else if (rsp_vld != '0) begin
      if (sbq.size() == 0 || sbq[0].due != cyc) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_rsp: rsp_vld=%b at cycle %0d, none required", rsp_vld, cyc);
      end else begin
        me = sbq.pop_front();
        chk("rsp_vld", 64'(rsp_vld), 64'(1 << me.port));
        chk("rsp_x", 64'(rsp_x), 64'(me.x));
        chk("rsp_y", 64'(rsp_y), 64'(me.y));
        chk("rsp_z", 64'(rsp_z), 64'(me.z));
      end
    end else if (sbq.size() != 0 && sbq[0].due == cyc) begin
      n_vec++; n_err++;
      $display("FAIL missing_rsp: rsp_vld=0 at cycle %0d, required port %0d", cyc, sbq[0].port);
      void'(sbq.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int s);
    for (int k = 0; k < N; k++) begin
      req_x[k*W +: W] = W'(32'h1000 + k * 32'h0800 + s * 32'h40);
      req_y[k*W +: W] = W'(32'h0800 - k * 32'h0300 + s);
      req_z[k*W +: W] = W'(k * 32'h3000 + s * 32'h0111);
    end
  endtask

  task automatic idle(input int n);
    req_vld = '0;
    for (int i = 0; i < n; i++) tick();
  endtask

  int acc_cyc, ones, dx, dy, got, nstr;
  logic [N-1:0] ord [8];
  int           ocy [8];

  initial begin
    rst = 1'b1; req_vld = '1; req_x = '0; req_y = '0; req_z = '0;
    tick(); tick();
    chk("reset_req_rdy", 64'(req_rdy), 64'(0));
    chk("reset_core_x", 64'(core_x), 64'(0));
    chk("reset_inflight", 64'(inflight), 64'(0));
    chk("reset_busy", 64'(busy), 64'(0));
    req_vld = '0;

    // Test 1: single 45 degree rotation on port 2, first cycle out of reset.
    rst = 1'b0;
    req_vld = 4'b0100;
    req_x[2*W +: W] = 16'h4000; req_y[2*W +: W] = 16'h0000; req_z[2*W +: W] = 16'h2000;
    #1;
    chk("t1_grant", 64'(req_rdy), 64'(4'b0100));
    acc_cyc = cyc;
    tick();
    req_vld = '0;
    ones = 0; got = 0;
    for (int i = 0; i < 40 && got == 0; i++) begin
      if (inflight == CW'(1)) ones++;
      if (rsp_vld != '0) begin
        got = 1;
        chk("t1_latency", 64'(cyc - acc_cyc), 64'(22));
        chk("t1_rsp_vld", 64'(rsp_vld), 64'(4'b0100));
        dx = int'($signed(rsp_x)) - 32'h2D41;
        dy = int'($signed(rsp_y)) - 32'h2D41;
        chk("t1_rsp_x_within_2", 64'(dx >= -2 && dx <= 2), 64'(1));
        chk("t1_rsp_y_within_2", 64'(dy >= -2 && dy <= 2), 64'(1));
      end else tick();
    end
    chk("t1_strobe_seen", 64'(got), 64'(1));
    chk("t1_inflight_one_cycles", 64'(ones), 64'(22));
    idle(5);

    // Test 2: all ports valid for 8 cycles straight out of reset.
    rst = 1'b1; tick(); rst = 1'b0; peak = 0;
    for (int i = 0; i < 8; i++) begin
      req_vld = '1; set_ops(i);
      #1;
      chk("t2_grant_order", 64'(req_rdy), 64'(1 << (i % 4)));
      tick();
    end
    req_vld = '0;
    nstr = 0;
    for (int i = 0; i < 40; i++) begin
      if (rsp_vld != '0 && nstr < 8) begin
        ord[nstr] = rsp_vld; ocy[nstr] = cyc; nstr++;
      end
      tick();
    end
    chk("t2_strobe_count", 64'(nstr), 64'(8));
    for (int i = 0; i < nstr; i++) begin
      chk("t2_strobe_order", 64'(ord[i]), 64'(1 << (i % 4)));
      if (i > 0) chk("t2_strobe_consecutive", 64'(ocy[i] - ocy[i-1]), 64'(1));
    end
    chk("t2_inflight_peak", 64'(peak), 64'(8));

    // Test 3: make ptr = 2 via a port-1 grant, then ports 1 and 3 compete.
    req_vld = 4'b0010; set_ops(20); tick();
    req_vld = 4'b1010; set_ops(21);
    #1;
    chk("t3_first_grant", 64'(req_rdy), 64'(4'b1000));
    tick();
    chk("t3_second_grant", 64'(req_rdy), 64'(4'b0010));
    tick();
    idle(30);

    // Test 4: reset five cycles after three acceptances discards them.
    req_vld = 4'b0001;
    for (int i = 0; i < 3; i++) begin set_ops(30 + i); tick(); end
    idle(5);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t4_inflight_after_reset", 64'(inflight), 64'(0));
    chk("t4_busy_after_reset", 64'(busy), 64'(0));
    nstr = 0;
    for (int i = 0; i < 30; i++) begin
      if (rsp_vld != '0) nstr++;
      tick();
    end
    chk("t4_no_strobes", 64'(nstr), 64'(0));

    // Test 5: one request per cycle for 100 cycles with random operands.
    peak = 0;
    for (int i = 0; i < 100; i++) begin
      req_vld = 4'(1 << (i % 4));
      for (int k = 0; k < N; k++) begin
        req_x[k*W +: W] = W'($urandom_range(24000) - 12000);
        req_y[k*W +: W] = W'($urandom_range(24000) - 12000);
        req_z[k*W +: W] = W'($urandom);
      end
      tick();
    end
    idle(30);
    chk("t5_inflight_peak", 64'(peak), 64'(22));

    // Test 6: ports 0 and 1 continuously valid.
    for (int i = 0; i < 6; i++) begin
      req_vld = 4'b0011; set_ops(40 + i);
      #1;
`ifdef CORDIC_SCHED_PRIO0_EN
      chk("t6_grant_prio0", 64'(req_rdy), 64'(4'b0001));
`else
      chk("t6_grant_alternate", 64'(req_rdy), 64'((i % 2 == 0) ? 4'b0001 : 4'b0010));
`endif
      tick();
    end
    idle(30);
    chk("scoreboard_drained", 64'(sbq.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete, %0d miscompares so far", n_err);
    $fatal(1);
  end

endmodule
